// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - shared types and sizing helpers for the track controller
package aud_pkg;

    typedef enum logic [2:0] {
        S_INIT       = 3'd0,
        S_IDLE       = 3'd1,
        S_REC        = 3'd2,
        S_REC_PAUSE  = 3'd3,
        S_PLAY       = 3'd4,
        S_PLAY_PAUSE = 3'd5
    } aud_state_e;

    localparam int AUD_ADDR_MAX = 32;
    localparam int AUD_DATA_MAX = 32;

    // Fields sized for the widest supported port; users narrow them with casts.
    typedef struct packed {
        logic [AUD_ADDR_MAX-1:0] addr;
        logic [AUD_DATA_MAX-1:0] wdata;
        logic                    we_n;
        logic                    oe_n;
    } aud_sram_req_t;

    function automatic int aud_slot_w(input int num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

    function automatic int aud_reg_w(input int addr_w, input int num_slots);
        return addr_w - aud_slot_w(num_slots);
    endfunction

endpackage

// File: rtl/aud_rd_pipe.sv
// rtl/aud_rd_pipe.sv - tracks in-flight SRAM reads and captures returned samples
module aud_rd_pipe #(
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_issue,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_busy
);

    // Bit k set means a read whose address went out k+1 edges ago is pending.
    logic [RD_LAT-1:0] r_sh;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh    <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            r_sh    <= RD_LAT'({r_sh, i_issue});
            o_valid <= r_sh[RD_LAT-1];
            if (r_sh[RD_LAT-1]) begin
                o_data <= i_rdata;
            end
        end
    end

    assign o_busy = |r_sh;

endmodule

// File: rtl/aud_track_ctrl.sv
// rtl/aud_track_ctrl.sv - record/playback sequencer owning the external SRAM port
module aud_track_ctrl
    import aud_pkg::*;
#(
    parameter int ADDR_W          = 20,
    parameter int DATA_W          = 16,
    parameter int NUM_SLOTS       = 4,
    parameter int RD_LAT          = 2,
    parameter int SAMPLES_PER_SEC = 32000,
    parameter int SEC_W           = 6,
    localparam int SLOT_W         = aud_slot_w(NUM_SLOTS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_init_done,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_mode_play,
    input  logic              i_loop,
    input  logic [SLOT_W-1:0] i_slot,
    input  logic              i_rec_valid,
    input  logic [DATA_W-1:0] i_rec_data,
    input  logic              i_play_req,
    output logic [DATA_W-1:0] o_play_data,
    output logic              o_play_valid,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic [2:0]        o_state,
    output logic [SEC_W-1:0]  o_seconds,
    output logic              o_done
);

    localparam int REG_W  = aud_reg_w(ADDR_W, NUM_SLOTS);
    localparam int SAMP_W = (SAMPLES_PER_SEC > 1) ? $clog2(SAMPLES_PER_SEC) : 1;
    localparam logic [REG_W:0]    LEN_FULL  = {1'b1, {REG_W{1'b0}}};
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMPLES_PER_SEC - 1);

    aud_state_e        r_state;
    aud_state_e        w_state_nxt;
    logic [SLOT_W-1:0] r_slot;
    logic [REG_W:0]    r_ptr;
    logic [REG_W:0]    r_len [NUM_SLOTS];
    logic [SAMP_W-1:0] r_samp;
    aud_sram_req_t     r_req;

    logic [REG_W:0]    w_ptr_inc;
    logic [REG_W:0]    w_cur_len;
    logic [REG_W:0]    w_sel_len;
    logic              w_start_idle;
    logic              w_wr_acc;
    logic              w_rd_issue;
    logic              w_commit;
    logic              w_wrap;
    logic              w_done_nxt;
    logic              w_rd_busy;

    assign w_ptr_inc = r_ptr + (REG_W+1)'(1);
    assign w_cur_len = r_len[r_slot];
    assign w_sel_len = r_len[i_slot];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_idle = 1'b0;
        w_wr_acc     = 1'b0;
        w_rd_issue   = 1'b0;
        w_commit     = 1'b0;
        w_wrap       = 1'b0;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_INIT: begin
                if (i_init_done) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (i_start && !i_stop && !i_pause) begin
                    w_start_idle = 1'b1;
                    if (!i_mode_play)         w_state_nxt = S_REC;
                    else if (w_sel_len != '0) w_state_nxt = S_PLAY;
                    else                      w_done_nxt  = 1'b1;
                end
            end
            S_REC: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                    w_commit    = 1'b1;
                end else if (i_pause) begin
                    w_state_nxt = S_REC_PAUSE;
                end else if (r_ptr == LEN_FULL) begin
                    w_state_nxt = S_IDLE;
                    w_commit    = 1'b1;
                    w_done_nxt  = 1'b1;
                end else if (i_rec_valid) begin
                    w_wr_acc = 1'b1;
                end
            end
            S_REC_PAUSE: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                    w_commit    = 1'b1;
                end else if (i_start && !i_pause) begin
                    w_state_nxt = S_REC;
                end
            end
            S_PLAY: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (i_pause) begin
                    w_state_nxt = S_PLAY_PAUSE;
                end else if (r_ptr == w_cur_len) begin
                    // Track exhausted: finish once the last read has been delivered.
                    if (!w_rd_busy) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else if (i_play_req) begin
                    w_rd_issue = 1'b1;
                    w_wrap     = i_loop && (w_ptr_inc == w_cur_len);
                end
            end
            S_PLAY_PAUSE: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                end else if (i_start && !i_pause) begin
                    w_state_nxt = S_PLAY;
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot     <= '0;
            r_ptr      <= '0;
            r_samp     <= '0;
            o_seconds  <= '0;
            o_done     <= 1'b0;
            r_req.addr  <= '0;
            r_req.wdata <= '0;
            r_req.we_n  <= 1'b1;
            r_req.oe_n  <= 1'b1;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_len[i] <= '0;
            end
        end else begin
            r_req.we_n <= 1'b1;
            r_req.oe_n <= 1'b1;
            o_done     <= w_done_nxt;
            if (w_start_idle) begin
                r_slot    <= i_slot;
                r_ptr     <= '0;
                r_samp    <= '0;
                o_seconds <= '0;
                if (!i_mode_play) r_len[i_slot] <= '0;
            end
            if (w_commit) begin
                r_len[r_slot] <= r_ptr;
            end
            if (w_wr_acc) begin
                r_req.addr  <= AUD_ADDR_MAX'({r_slot, r_ptr[REG_W-1:0]});
                r_req.wdata <= AUD_DATA_MAX'(i_rec_data);
                r_req.we_n  <= 1'b0;
                r_ptr       <= w_ptr_inc;
            end
            if (w_rd_issue) begin
                r_req.addr <= AUD_ADDR_MAX'({r_slot, r_ptr[REG_W-1:0]});
                r_req.oe_n <= 1'b0;
                r_ptr      <= w_wrap ? '0 : w_ptr_inc;
            end
            if (w_wr_acc || w_rd_issue) begin
                if (r_samp == SAMP_LAST) begin
                    r_samp <= '0;
                    if (o_seconds != '1) o_seconds <= o_seconds + SEC_W'(1);
                end else begin
                    r_samp <= r_samp + SAMP_W'(1);
                end
            end
            // Looping restarts the elapsed time along with the track.
            if (w_wrap) begin
                r_samp    <= '0;
                o_seconds <= '0;
            end
        end
    end

    assign o_sram_addr  = ADDR_W'(r_req.addr);
    assign o_sram_wdata = DATA_W'(r_req.wdata);
    assign o_sram_we_n  = r_req.we_n;
    assign o_sram_oe_n  = r_req.oe_n;
    assign o_state      = r_state;

    aud_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_issue (w_rd_issue),
        .i_rdata (i_sram_rdata),
        .o_data  (o_play_data),
        .o_valid (o_play_valid),
        .o_busy  (w_rd_busy)
    );

endmodule

// File: doc/aud_track_ctrl.md
Name: aud_track_ctrl

Overview:
Parametrised record/playback controller that owns the external SRAM port. It sequences init-wait, record and play modes. SRAM is split into NUM_SLOTS equal track regions, and the recorded length of each slot is tracked. Adds pause/resume, per-slot lengths, loop playback and a read-latency-aware sample handshake toward the player DSP. It sits between the codec recorder/player datapaths and the SRAM pins, below the top-level button and switch decode.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 16, sample/SRAM data width
NUM_SLOTS, 4, track regions; power of 2, at least 2
RD_LAT, 2, cycles from read address to valid i_sram_rdata; range 1..4
SAMPLES_PER_SEC, 32000, samples per elapsed-second tick
SEC_W, 6, elapsed-seconds counter width

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_init_done  in  1  codec I2C init finished (level)
i_start  in  1  start/resume pulse, 1 cycle
i_pause  in  1  pause pulse
i_stop  in  1  stop pulse
i_mode_play  in  1  1=play, 0=record; sampled only on start from IDLE
i_loop  in  1  play wraps to slot start instead of ending
i_slot  in  SLOT_W  target slot; SLOT_W=$clog2(NUM_SLOTS); sampled on start from IDLE
i_rec_valid  in  1  recorder sample strobe
i_rec_data  in  DATA_W  recorder sample
i_play_req  in  1  player requests next sample
o_play_data  out  DATA_W  sample returned to player
o_play_valid  out  1  o_play_data valid, 1 cycle
o_sram_addr  out  ADDR_W  SRAM address
o_sram_wdata  out  DATA_W  SRAM write data
o_sram_we_n  out  1  write strobe, active low
o_sram_oe_n  out  1  output enable, active low
i_sram_rdata  in  DATA_W  SRAM read data
o_state  out  3  current state encoding
o_seconds  out  SEC_W  elapsed seconds of the current operation
o_done  out  1  1-cycle pulse on auto-stop (slot full or end of track)

Behaviour:
- Single clock i_clk; reset asynchronous, active-low i_rst_n. All outputs registered.
- Reset values: state=S_INIT, all slot lengths 0, pointers 0, o_seconds 0, o_sram_we_n 1, o_sram_oe_n 1, o_play_valid 0, o_done 0, o_sram_addr 0, o_play_data 0.
- Region layout: REG_W = ADDR_W-SLOT_W. Address = {slot, ptr[REG_W-1:0]}. Length registers are REG_W+1 bits wide so a full region is representable.
- States: S_INIT, S_IDLE, S_REC, S_REC_PAUSE, S_PLAY, S_PLAY_PAUSE.
- S_INIT -> S_IDLE when i_init_done=1. Buttons are ignored in S_INIT.
- S_IDLE + i_start: latch slot and mode, clear ptr and o_seconds.
  - Record: go to S_REC and set len[slot]=0.
  - Play with len[slot]>0: go to S_PLAY.
  - Play with len[slot]==0: pulse o_done next cycle and stay in S_IDLE.
- Priority within a cycle: stop > pause > start.
- i_stop in any non-INIT, non-IDLE state returns to S_IDLE.
  - Record: len[slot]=ptr is committed.
  - Play: any in-flight read still returns o_play_valid, then is dropped.
- i_pause moves REC->REC_PAUSE and PLAY->PLAY_PAUSE. i_start resumes; ptr and o_seconds are retained.
- S_REC write path: i_rec_valid causes the next cycle to drive addr={slot,ptr}, wdata=i_rec_data, we_n=0 for exactly 1 cycle. Then ptr++.
- i_rec_valid in REC_PAUSE is ignored.
- Record full: when ptr reaches 2^REG_W, commit len=2^REG_W, pulse o_done, go to S_IDLE. A further i_rec_valid in that cycle is dropped.
- S_PLAY read path: i_play_req drives addr, oe_n=0 for 1 cycle, and ptr++.
  - o_play_data = i_sram_rdata captured RD_LAT cycles after the address cycle.
  - o_play_valid pulses in that same capture cycle.
  - Requests are pipelined: one per cycle is accepted. A shift register of depth RD_LAT tracks in-flight reads.
- End of track: when ptr reaches len[slot] after an issued read:
  - i_loop=1: ptr wraps to 0 and o_seconds clears.
  - i_loop=0: pulse o_done after the last o_play_valid, then go to S_IDLE.
  - Requests beyond len are not issued.
- i_play_req in PLAY_PAUSE is ignored, but outstanding reads still complete.
- o_we_n and o_oe_n are never both 0. Outside REC and PLAY both are 1.
- Seconds counter:
  - A sample counter increments per accepted write or read.
  - At SAMPLES_PER_SEC-1 the sample counter wraps and o_seconds increments, saturating at 2^SEC_W-1.
  - o_seconds holds its value in pause and IDLE and clears only on start from IDLE.
- i_mode_play and i_slot changes mid-operation have no effect.
- Reset mid-operation aborts immediately, with SRAM strobes deasserted asynchronously.
- Slot lengths survive stop but not reset.

Decomposition:
- Package aud_pkg holds the state enum typedef (3 bits, values in the order listed above), an SRAM request struct {addr, wdata, we_n, oe_n}, and a function computing SLOT_W/REG_W.
- One sub-module: aud_rd_pipe (RD_LAT-deep valid/capture shift register producing o_play_valid and o_play_data).

Test Plan:
- Init wait: i_init_done=0 for 10 cycles plus i_start pulses -> state stays S_INIT. Raise i_init_done -> S_IDLE next cycle.
- Record slot 2, 5 rec_valid, then stop:
  - 5 write cycles at addr {2,0..4}, we_n=0 for 1 cycle each.
  - len[2]=5 afterwards.
  - Play slot 2 with 5 back-to-back requests returns the same 5 samples RD_LAT cycles later, then o_done pulses once.
- Full region with ADDR_W=6, NUM_SLOTS=4: 16 writes set len=16, o_done pulses, state goes to IDLE. The 17th rec_valid produces no write.
- Loop play with len=3 and 7 requests: addresses 0,1,2,0,1,2,0; no o_done.
- Same-cycle i_stop+i_pause during S_PLAY -> S_IDLE, and an outstanding read still yields 1 o_play_valid.
- Seconds: SAMPLES_PER_SEC=4, SEC_W=2, 20 writes -> o_seconds=3 (saturated).
- Pause then resume keeps o_seconds and ptr unchanged.
- Play of an empty slot -> o_done pulse, stays S_IDLE.
